// File: rtl/grapheme_node_prot_pkg.sv
// Shared gnode protocol types: stream commands, header layout, ingress FSM states and slice word.
package grapheme_node_prot_pkg;

    typedef enum logic [1:0] {
        GNODE_IDLE  = 2'd0,
        GNODE_SOP   = 2'd1,
        GNODE_VALID = 2'd2,
        GNODE_EOP   = 2'd3
    } gnode_prot_cmd_t;

    // Header carried on the SOP word; job_dst sits in the low byte.
    typedef struct packed {
        logic [7:0] job_id;
        logic [7:0] job_type;
        logic [7:0] job_src;
        logic [7:0] job_dst;
    } gnode_prot_hdr_t;

    localparam logic [7:0] GNODE_JOB_WRITE_PXL = 8'h01;
    localparam logic [7:0] GNODE_BCAST_ID      = 8'hFF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOCAL,
        S_BYPASS,
        S_TRUNC
    } gnode_rx_fsm_t;

    typedef struct packed {
        gnode_prot_cmd_t cmd;
        logic [31:0]     data;
    } gnode_slice_t;

endpackage

// File: rtl/grapheme_node_pipe_slice.sv
// Single-entry registered cmd/data slice; one cycle latency.
// Accepts a new word whenever empty or being drained the same cycle, so streaming has no bubbles.
module grapheme_node_pipe_slice
    import grapheme_node_prot_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  gnode_slice_t load_word,
    output logic         ready,
    output gnode_slice_t word,
    input  logic         down_ready
);

    logic full;

    assign full  = (word.cmd != GNODE_IDLE);
    assign ready = !full || down_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '{cmd: GNODE_IDLE, data: 32'h0};
        end else if (load && ready) begin
            word <= load_word;
        end else if (down_ready) begin
            word <= '{cmd: GNODE_IDLE, data: 32'h0};
        end
    end

endmodule

// File: rtl/grapheme_node_rx_parser.sv
// Ring ingress: decodes the SOP header and steers each packet to the local job engine or bypass.
// One cycle latency per path; malformed words are dropped and truncated packets get a synthetic EOP.
module grapheme_node_rx_parser
    import grapheme_node_prot_pkg::*;
#(
    parameter logic [7:0] NODE_ID  = 8'h00,
    parameter logic [7:0] BCAST_ID = GNODE_BCAST_ID,
    parameter int         CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       ingr_cmd,
    input  logic [31:0]      ingr_data,
    output logic             ingr_ready,
    output logic [1:0]       loc_cmd,
    output logic [31:0]      loc_data,
    input  logic             loc_ready,
    output logic [7:0]       loc_job_id,
    output logic [7:0]       loc_job_type,
    output logic [7:0]       loc_job_src,
    output logic [1:0]       byp_cmd,
    output logic [31:0]      byp_data,
    input  logic             byp_ready,
    output logic [CNT_W-1:0] cnt_local,
    output logic [CNT_W-1:0] cnt_bypass,
    output logic [CNT_W-1:0] cnt_err
);

    gnode_rx_fsm_t   state;
    logic            trunc_local;
    gnode_prot_cmd_t cmd;
    gnode_prot_hdr_t hdr;
    logic            is_local;
    logic            ready_int;
    logic            xfer;
    logic            loc_load, byp_load;
    logic            loc_slice_rdy, byp_slice_rdy;
    gnode_slice_t    push_word, loc_word, byp_word;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + CNT_W'(1);
    endfunction

    assign cmd      = gnode_prot_cmd_t'(ingr_cmd);
    assign hdr      = gnode_prot_hdr_t'(ingr_data);
    assign is_local = (hdr.job_dst == NODE_ID) || (hdr.job_dst == BCAST_ID);

    always_comb begin
        ready_int = 1'b0;
        loc_load  = 1'b0;
        byp_load  = 1'b0;
        push_word = '{cmd: cmd, data: ingr_data};
        case (state)
            S_IDLE: begin
                if (cmd == GNODE_SOP) begin
                    ready_int = is_local ? loc_slice_rdy : byp_slice_rdy;
                    loc_load  = is_local && loc_slice_rdy;
                    byp_load  = !is_local && byp_slice_rdy;
                end else if (cmd != GNODE_IDLE) begin
                    ready_int = 1'b1;
                end
            end
            S_LOCAL: begin
                // A new SOP mid-packet is held back until the truncation EOP is out.
                if (cmd != GNODE_SOP) begin
                    ready_int = loc_slice_rdy;
                    loc_load  = (cmd != GNODE_IDLE) && loc_slice_rdy;
                end
            end
            S_BYPASS: begin
                if (cmd != GNODE_SOP) begin
                    ready_int = byp_slice_rdy;
                    byp_load  = (cmd != GNODE_IDLE) && byp_slice_rdy;
                end
            end
            S_TRUNC: begin
                push_word = '{cmd: GNODE_EOP, data: 32'h0};
                loc_load  = trunc_local && loc_slice_rdy;
                byp_load  = !trunc_local && byp_slice_rdy;
            end
            default: ;
        endcase
    end

    assign ingr_ready = rst_n && ready_int;
    assign xfer       = (cmd != GNODE_IDLE) && ingr_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            trunc_local  <= 1'b0;
            loc_job_id   <= 8'h0;
            loc_job_type <= 8'h0;
            loc_job_src  <= 8'h0;
            cnt_local    <= '0;
            cnt_bypass   <= '0;
            cnt_err      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (xfer) begin
                        if (cmd == GNODE_SOP) begin
                            if (is_local) begin
                                loc_job_id   <= hdr.job_id;
                                loc_job_type <= hdr.job_type;
                                loc_job_src  <= hdr.job_src;
                                cnt_local    <= sat_inc(cnt_local);
                                state        <= S_LOCAL;
                            end else begin
                                cnt_bypass <= sat_inc(cnt_bypass);
                                state      <= S_BYPASS;
                            end
                        end else begin
                            cnt_err <= sat_inc(cnt_err);
                        end
                    end
                end
                S_LOCAL, S_BYPASS: begin
                    if (cmd == GNODE_SOP) begin
                        trunc_local <= (state == S_LOCAL);
                        state       <= S_TRUNC;
                    end else if (xfer && cmd == GNODE_EOP) begin
                        state <= S_IDLE;
                    end
                end
                S_TRUNC: begin
                    if (loc_load || byp_load) begin
                        cnt_err <= sat_inc(cnt_err);
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    grapheme_node_pipe_slice u_loc_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (loc_load),
        .load_word  (push_word),
        .ready      (loc_slice_rdy),
        .word       (loc_word),
        .down_ready (loc_ready)
    );

    grapheme_node_pipe_slice u_byp_slice (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (byp_load),
        .load_word  (push_word),
        .ready      (byp_slice_rdy),
        .word       (byp_word),
        .down_ready (byp_ready)
    );

    assign loc_cmd  = loc_word.cmd;
    assign loc_data = loc_word.data;
    assign byp_cmd  = byp_word.cmd;
    assign byp_data = byp_word.data;

endmodule

// File: tb/tb_grapheme_node_rx_parser.sv
// Directed bench for the ingress parser; narrow counters keep the saturation sweep short.
module tb_grapheme_node_rx_parser;

    localparam int CNT_W = 4;
    localparam logic [1:0] C_IDLE = 2'd0, C_SOP = 2'd1, C_VALID = 2'd2, C_EOP = 2'd3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       ingr_cmd = 2'd0;
    logic [31:0]      ingr_data = 32'h0;
    logic             ingr_ready;
    logic [1:0]       loc_cmd, byp_cmd;
    logic [31:0]      loc_data, byp_data;
    logic             loc_ready = 1'b1, byp_ready = 1'b1;
    logic [7:0]       loc_job_id, loc_job_type, loc_job_src;
    logic [CNT_W-1:0] cnt_local, cnt_bypass, cnt_err;

    always #5 clk = ~clk;

    grapheme_node_rx_parser #(.NODE_ID(8'h05), .BCAST_ID(8'hFF), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ingr_cmd(ingr_cmd), .ingr_data(ingr_data), .ingr_ready(ingr_ready),
        .loc_cmd(loc_cmd), .loc_data(loc_data), .loc_ready(loc_ready),
        .loc_job_id(loc_job_id), .loc_job_type(loc_job_type), .loc_job_src(loc_job_src),
        .byp_cmd(byp_cmd), .byp_data(byp_data), .byp_ready(byp_ready),
        .cnt_local(cnt_local), .cnt_bypass(cnt_bypass), .cnt_err(cnt_err)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every downstream transfer with the cycle it was presented.
    logic [33:0] loc_q[$], byp_q[$];
    int          loc_c[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (loc_cmd != C_IDLE && loc_ready) begin
                loc_q.push_back({loc_cmd, loc_data});
                loc_c.push_back(cyc);
            end
            if (byp_cmd != C_IDLE && byp_ready) byp_q.push_back({byp_cmd, byp_data});
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [33:0] qloc(input int i);
        return (i < loc_q.size()) ? loc_q[i] : 34'bx;
    endfunction

    function automatic logic [33:0] qbyp(input int i);
        return (i < byp_q.size()) ? byp_q[i] : 34'bx;
    endfunction

    // Present one word and hold it until the DUT accepts it; returns the acceptance cycle.
    task automatic send(input logic [1:0] c, input logic [31:0] d, output int t);
        int n;
        n = 0;
        ingr_cmd  = c;
        ingr_data = d;
        @(negedge clk);
        while (!ingr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ingr_ready_timeout", 64'(n), 64'(0));
        t = cyc;
        @(posedge clk);
        #1;
        ingr_cmd  = C_IDLE;
        ingr_data = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        loc_q.delete();
        loc_c.delete();
        byp_q.delete();
    endtask

    initial begin
        int t0, tx;
        logic [33:0] bp_exp [6];

        // Reset: an SOP addressed to us must not be accepted while rst_n is low.
        ingr_cmd  = C_SOP;
        ingr_data = 32'h01010205;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ingr_ready", 64'(ingr_ready), 64'(0));
        chk("rst_loc_cmd", 64'(loc_cmd), 64'(C_IDLE));
        chk("rst_byp_cmd", 64'(byp_cmd), 64'(C_IDLE));
        chk("rst_data", {loc_data, byp_data}, 64'h0);
        chk("rst_job", {loc_job_id, loc_job_type, loc_job_src}, 64'h0);
        chk("rst_cnts", {cnt_local, cnt_bypass, cnt_err}, 64'h0);
        @(posedge clk);
        #1;
        ingr_cmd = C_IDLE;
        rst_n    = 1'b1;
        idle(2);

        // Local packet: three words back-to-back, one cycle behind ingress.
        send(C_SOP, 32'h01010205, t0);
        send(C_VALID, 32'h0000000A, tx);
        send(C_EOP, 32'h0000000B, tx);
        idle(4);
        chk("t1_cnt", 64'(loc_q.size()), 64'(3));
        chk("t1_w0", 64'(qloc(0)), {30'h0, C_SOP, 32'h01010205});
        chk("t1_w1", 64'(qloc(1)), {30'h0, C_VALID, 32'h0000000A});
        chk("t1_w2", 64'(qloc(2)), {30'h0, C_EOP, 32'h0000000B});
        if (loc_c.size() == 3) begin
            chk("t1_lat", 64'(loc_c[0]), 64'(t0 + 1));
            chk("t1_b2b", 64'(loc_c[2] - loc_c[0]), 64'(2));
        end else chk("t1_cycles_recorded", 64'(loc_c.size()), 64'(3));
        chk("t1_job", {loc_job_id, loc_job_type, loc_job_src}, {40'h0, 8'd1, 8'd1, 8'd2});
        chk("t1_cnt_local", 64'(cnt_local), 64'(1));
        chk("t1_byp_none", 64'(byp_q.size()), 64'(0));
        clear_q();

        // Bypass packet: header fields must not touch the local job latches.
        send(C_SOP, 32'h07030409, tx);
        send(C_VALID, 32'h0000000A, tx);
        send(C_EOP, 32'h0000000B, tx);
        idle(4);
        chk("t2_w0", 64'(qbyp(0)), {30'h0, C_SOP, 32'h07030409});
        chk("t2_w1", 64'(qbyp(1)), {30'h0, C_VALID, 32'h0000000A});
        chk("t2_w2", 64'(qbyp(2)), {30'h0, C_EOP, 32'h0000000B});
        chk("t2_byp_cnt", 64'(byp_q.size()), 64'(3));
        chk("t2_loc_none", 64'(loc_q.size()), 64'(0));
        chk("t2_cnt_bypass", 64'(cnt_bypass), 64'(1));
        chk("t2_job_held", {loc_job_id, loc_job_type, loc_job_src}, {40'h0, 8'd1, 8'd1, 8'd2});
        clear_q();

        // Broadcast single-header packet goes local only.
        send(C_SOP, 32'h020103FF, tx);
        send(C_EOP, 32'h0000000C, tx);
        idle(4);
        chk("t3_w0", 64'(qloc(0)), {30'h0, C_SOP, 32'h020103FF});
        chk("t3_w1", 64'(qloc(1)), {30'h0, C_EOP, 32'h0000000C});
        chk("t3_byp_none", 64'(byp_q.size()), 64'(0));
        chk("t3_cnts", {cnt_local, cnt_bypass}, 64'h21);
        chk("t3_job_src", 64'(loc_job_src), 64'h03);
        clear_q();

        // Stray VALID in idle is consumed and dropped.
        send(C_VALID, 32'h00001234, tx);
        idle(4);
        chk("t4_cnt_err", 64'(cnt_err), 64'(1));
        chk("t4_no_out", 64'(loc_q.size() + byp_q.size()), 64'(0));
        clear_q();

        // Missing EOP: synthetic EOP closes the local packet, the held SOP goes to bypass.
        send(C_SOP, 32'h03010205, tx);
        send(C_VALID, 32'h00000001, tx);
        send(C_SOP, 32'h04010209, tx);
        send(C_VALID, 32'h00000002, tx);
        send(C_EOP, 32'h00000003, tx);
        idle(4);
        chk("t5_loc_cnt", 64'(loc_q.size()), 64'(3));
        chk("t5_loc_w2", 64'(qloc(2)), {30'h0, C_EOP, 32'h0});
        chk("t5_loc_w1", 64'(qloc(1)), {30'h0, C_VALID, 32'h1});
        chk("t5_byp_w0", 64'(qbyp(0)), {30'h0, C_SOP, 32'h04010209});
        chk("t5_byp_w2", 64'(qbyp(2)), {30'h0, C_EOP, 32'h3});
        chk("t5_cnt_err", 64'(cnt_err), 64'(2));
        chk("t5_cnts", {cnt_local, cnt_bypass}, 64'h32);
        clear_q();

        // Backpressure: local consumer stalls for 4 cycles mid-packet.
        bp_exp[0] = {C_SOP, 32'h05010205};
        for (int i = 1; i < 5; i++) bp_exp[i] = {C_VALID, 32'(16 + i)};
        bp_exp[5] = {C_EOP, 32'h00000099};
        fork
            begin
                for (int i = 0; i < 6; i++) send(bp_exp[i][33:32], bp_exp[i][31:0], tx);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                loc_ready = 1'b0;
                @(negedge clk);
                chk("t6_ready_drop", 64'(ingr_ready), 64'(0));
                repeat (4) @(posedge clk);
                #1;
                loc_ready = 1'b1;
            end
        join
        idle(4);
        chk("t6_cnt", 64'(loc_q.size()), 64'(6));
        for (int i = 0; i < 6; i++) chk($sformatf("t6_w%0d", i), 64'(qloc(i)), 64'(bp_exp[i]));
        chk("t6_cnt_local", 64'(cnt_local), 64'(4));
        clear_q();

        // Saturation: 14 more local packets and 20 stray words overrun the 4-bit counters.
        for (int i = 0; i < 14; i++) begin
            send(C_SOP, 32'h0A0A0A05, tx);
            send(C_EOP, 32'h0, tx);
        end
        for (int i = 0; i < 20; i++) send(C_VALID, 32'(i), tx);
        idle(4);
        chk("sat_cnt_local", 64'(cnt_local), 64'hF);
        chk("sat_cnt_err", 64'(cnt_err), 64'hF);
        chk("sat_cnt_bypass", 64'(cnt_bypass), 64'(2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
